// File: rtl/axi_master_read_channel.sv
// ---------------------------------------------------------------------------------------------
// axi_master_read_channel
//
// AXI read-side initiator. Accepts one burst-read request at a time from the core/cache side,
// issues it on the AR channel, steers the returning R beats into a line-fill write port and
// reports one completion pulse per request together with an error flag.
//
// Optional feature (compile-time macro AXI_MRD_TIMEOUT_EN):
//   defined   - while collecting data, TIMEOUT_CYCLES consecutive cycles without an accepted
//               beat abort the burst: RREADY drops, the error flag is set and the request
//               completes.
//   undefined - no idle counter; the data phase waits indefinitely for the slave.
//
// Parameters:
//   ADDR_WIDTH          address width
//   READ_CHANNEL_WIDTH  data bits per beat
//   READ_BURST_LEN      width of ARLEN, request length and beat index
//   TIMEOUT_CYCLES      max idle cycles between R beats (only with the macro)
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready           request handshake from the core side
//   req_addr, req_len             burst start address, beats minus one
//   ARVALID/ARREADY               AR channel handshake
//   ARADDR, ARLEN                 registered request address/length, stable while ARVALID
//   ARSIZE, ARBURST               constant full-width beats, INCR burst
//   RVALID/RREADY                 R channel handshake
//   RDATA, RLAST, RRESP           beat payload
//   fill_stall                    fill sink cannot take a beat this cycle
//   fill_we, fill_idx, fill_data  line-fill write port, same cycle as the accepted beat
//   done, err                     one-cycle completion pulse, error status valid with done
// ---------------------------------------------------------------------------------------------
module axi_master_read_channel #(
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned READ_CHANNEL_WIDTH = 32,
    parameter int unsigned READ_BURST_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    // Core-side request
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [READ_BURST_LEN-1:0]     req_len,
    // AXI read-address channel
    output logic                          ARVALID,
    input  logic                          ARREADY,
    output logic [ADDR_WIDTH-1:0]         ARADDR,
    output logic [READ_BURST_LEN-1:0]     ARLEN,
    output logic [2:0]                    ARSIZE,
    output logic [1:0]                    ARBURST,
    // AXI read-data channel
    input  logic                          RVALID,
    input  logic [READ_CHANNEL_WIDTH-1:0] RDATA,
    input  logic                          RLAST,
    input  logic [1:0]                    RRESP,
    output logic                          RREADY,
    // Line-fill write port
    input  logic                          fill_stall,
    output logic                          fill_we,
    output logic [READ_BURST_LEN-1:0]     fill_idx,
    output logic [READ_CHANNEL_WIDTH-1:0] fill_data,
    // Completion
    output logic                          done,
    output logic                          err
);

    localparam int unsigned BEAT_BYTES = READ_CHANNEL_WIDTH / 8;
    localparam logic [2:0]  SIZE_ENC   = 3'($clog2(BEAT_BYTES));
    localparam logic [1:0]  BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDone
    } state_e;

    state_e                      state_q;
    logic [ADDR_WIDTH-1:0]       araddr_q;
    logic [READ_BURST_LEN-1:0]   arlen_q;
    logic                        arvalid_q;
    logic [READ_BURST_LEN-1:0]   beat_cnt_q;
    logic                        err_sticky_q;
    logic                        done_q;
    logic                        err_q;

    logic                        beat;
    logic                        cnt_at_len;
    logic                        burst_end;
    logic                        end_mismatch;
    logic                        beat_err;
    logic                        tmo_expire;

    // -----------------------------------------------------------------------------------------
    // Beat decode
    // -----------------------------------------------------------------------------------------
    // RREADY depends only on state and the sink, never on RVALID.
    assign RREADY       = (state_q == StData) && !fill_stall;
    assign beat         = RVALID && RREADY;
    assign cnt_at_len   = (beat_cnt_q == arlen_q);
    // The burst ends on whichever of RLAST / counter==len comes first; any disagreement
    // between the two is a protocol error. The counter never advances past len, so a
    // maximum-length burst cannot wrap before this compare.
    assign burst_end    = beat && (RLAST || cnt_at_len);
    assign end_mismatch = (RLAST != cnt_at_len);
    // SLVERR and DECERR both have RRESP[1] set; OKAY and EXOKAY do not.
    assign beat_err     = RRESP[1];

    // -----------------------------------------------------------------------------------------
    // Optional inter-beat idle timeout
    // -----------------------------------------------------------------------------------------
`ifdef AXI_MRD_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // Counts beatless cycles in the data phase; expiry fires on the TIMEOUT_CYCLES-th one.
    logic [TMO_W-1:0] tmo_q;

    assign tmo_expire = !beat && (tmo_q == TMO_LAST);
`else
    assign tmo_expire = 1'b0;
`endif

    // RRESP[0] carries no information here and the timeout parameter is unused when the
    // feature is compiled out.
    logic unused_inputs;
    assign unused_inputs = RRESP[0] ^ (^TIMEOUT_CYCLES);

    // -----------------------------------------------------------------------------------------
    // Control FSM and registered outputs
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            beat_cnt_q   <= '0;
            err_sticky_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef AXI_MRD_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            // done/err are single-cycle pulses unless re-asserted below.
            done_q <= 1'b0;
            err_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        araddr_q     <= req_addr;
                        arlen_q      <= req_len;
                        beat_cnt_q   <= '0;
                        err_sticky_q <= 1'b0;
                        arvalid_q    <= 1'b1;
                        state_q      <= StAddr;
                    end
                end

                StAddr: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        state_q   <= StData;
`ifdef AXI_MRD_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end
                end

                StData: begin
                    if (beat) begin
                        beat_cnt_q <= beat_cnt_q + READ_BURST_LEN'(1);
`ifdef AXI_MRD_TIMEOUT_EN
                        tmo_q      <= '0;
`endif
                        if (burst_end) begin
                            done_q  <= 1'b1;
                            err_q   <= err_sticky_q | beat_err | end_mismatch;
                            state_q <= StDone;
                        end else begin
                            err_sticky_q <= err_sticky_q | beat_err;
                        end
                    end else if (tmo_expire) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
`ifdef AXI_MRD_TIMEOUT_EN
                        tmo_q <= tmo_q + TMO_W'(1);
`endif
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    // Gated by rst so the block never advertises readiness while held in reset.
    assign req_ready = (state_q == StIdle) && !rst;

    assign ARVALID   = arvalid_q;
    assign ARADDR    = araddr_q;
    assign ARLEN     = arlen_q;
    assign ARSIZE    = SIZE_ENC;
    assign ARBURST   = BURST_INCR;

    // Fill port follows the accepted beat in the same cycle; idle value is zero.
    assign fill_we   = beat;
    assign fill_idx  = beat ? beat_cnt_q : '0;
    assign fill_data = beat ? RDATA : '0;

    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_axi_master_read_channel.sv
// Bench for axi_master_read_channel: a transaction-level model predicts, for every request,
// the list of beats the slave will deliver and which of them must reach the fill port, plus
// the error outcome; a per-cycle compare checks the DUT against the phase timeline.
module tb_axi_master_read_channel;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LW  = 8;
    localparam int TMO = 16;

    localparam int PH_IDLE = 0;
    localparam int PH_ADDR = 1;
    localparam int PH_DATA = 2;
    localparam int PH_DONE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          ARVALID;
    logic          ARREADY;
    logic [AW-1:0] ARADDR;
    logic [LW-1:0] ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          RVALID;
    logic [DW-1:0] RDATA;
    logic          RLAST;
    logic [1:0]    RRESP;
    logic          RREADY;
    logic          fill_stall;
    logic          fill_we;
    logic [LW-1:0] fill_idx;
    logic [DW-1:0] fill_data;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    axi_master_read_channel #(
        .ADDR_WIDTH        (AW),
        .READ_CHANNEL_WIDTH(DW),
        .READ_BURST_LEN    (LW),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .RVALID    (RVALID),
        .RDATA     (RDATA),
        .RLAST     (RLAST),
        .RRESP     (RRESP),
        .RREADY    (RREADY),
        .fill_stall(fill_stall),
        .fill_we   (fill_we),
        .fill_idx  (fill_idx),
        .fill_data (fill_data),
        .done      (done),
        .err       (err)
    );

    // Counters
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state
    int            phase = PH_IDLE;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_len  = '0;
    logic [DW-1:0] bdata[$];
    logic [1:0]    bresp[$];
    bit            blast[$];
    bit            m_mismatch = 0;
    bit            m_err = 0;
    int            m_cnt = 0;
    int            bptr  = 0;
    int            idle  = 0;
    bit            exp_we = 0;

    // Stimulus knobs
    int            p_req = 0, p_ar = 100, p_rv = 100, p_stall = 0;
    bit            force_req = 0;
    logic [AW-1:0] f_addr = '0;
    logic [LW-1:0] f_len  = '0;
    int            f_mode = -1, f_k = 0;
    bit            rand_resp = 0;
    int            patch_idx = -1;
    logic [1:0]    patch_val = 2'b00;
    int            stall_at = -1, stall_left = 0;
    bit            forced_stall = 0;
    int            stop_after = 100000;

    // Observations
    int wr_cnt = 0, acc_cyc = 0, done_cyc = 0, last_beat_cyc = 0, done_seen = 0, txn_done = 0;
    bit last_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, got no completion expected completion (cycle %0d)",
                 name, cyc);
    endtask

    // Beat list the slave will return for the accepted request.
    // mode 0: RLAST on beat len; 1: RLAST early on beat k; 2: no RLAST, len+1 beats.
    task automatic build_list();
        int mode, k, size, r;
        if (f_mode >= 0) begin
            mode = f_mode;
            k    = f_k;
        end else begin
            r    = int'($urandom_range(9));
            mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            k    = (m_len > 0) ? int'($urandom_range(int'(m_len) - 1)) : 0;
        end
        if (mode == 1 && m_len == 0) mode = 0;
        size = (mode == 1) ? k + 1 : int'(m_len) + 1;
        bdata.delete();
        bresp.delete();
        blast.delete();
        for (int i = 0; i < size; i++) begin
            logic [1:0] rs;
            rs = 2'b00;
            if (rand_resp) begin
                rs = ($urandom_range(9) == 0) ? 2'($urandom_range(3, 2)) : 2'($urandom_range(1));
            end
            if (i == patch_idx) rs = patch_val;
            bdata.push_back($urandom);
            bresp.push_back(rs);
            blast.push_back((mode == 0 && i == int'(m_len)) || (mode == 1 && i == k));
        end
        m_mismatch = (mode != 0);
    endtask

    task automatic drive();
        if (force_req) begin
            req_valid = 1'b1;
            req_addr  = f_addr;
            req_len   = f_len;
        end else begin
            req_valid = (p_req > 0) && ($urandom_range(99) < p_req);
            req_addr  = $urandom;
            req_len   = ($urandom_range(15) == 0) ? 8'($urandom) : 8'($urandom_range(7));
        end
        ARREADY      = ($urandom_range(99) < p_ar);
        forced_stall = (stall_left > 0) && (phase == PH_DATA) && (m_cnt == stall_at);
        fill_stall   = forced_stall || ($urandom_range(99) < p_stall);
        if (phase == PH_DATA && bptr < bdata.size() && bptr < stop_after &&
            $urandom_range(99) < p_rv) begin
            RVALID = 1'b1;
            RDATA  = bdata[bptr];
            RRESP  = bresp[bptr];
            RLAST  = blast[bptr];
        end else begin
            RVALID = 1'b0;
            RDATA  = $urandom;
            RRESP  = 2'($urandom);
            RLAST  = 1'($urandom);
        end
    endtask

    task automatic compare();
        bit exp_rr;
        exp_rr = (phase == PH_DATA) && !fill_stall;
        exp_we = exp_rr && RVALID;
        chk("req_ready", 64'(req_ready), 64'(phase == PH_IDLE));
        chk("arvalid", 64'(ARVALID), 64'(phase == PH_ADDR));
        chk("araddr", 64'(ARADDR), 64'(m_addr));
        chk("arlen", 64'(ARLEN), 64'(m_len));
        chk("arsize", 64'(ARSIZE), 64'd2);
        chk("arburst", 64'(ARBURST), 64'd1);
        chk("rready", 64'(RREADY), 64'(exp_rr));
        chk("fill_we", 64'(fill_we), 64'(exp_we));
        if (exp_we && m_cnt < bdata.size()) begin
            chk("fill_idx", 64'(fill_idx), 64'(m_cnt));
            chk("fill_data", 64'(fill_data), 64'(bdata[m_cnt]));
        end
        chk("done", 64'(done), 64'(phase == PH_DONE));
        if (phase == PH_DONE) chk("err", 64'(err), 64'(m_err));
        if (fill_we) wr_cnt++;
        if (done) begin
            done_seen++;
            done_cyc = cyc;
            last_err = err;
        end
    endtask

    task automatic update();
        if (RVALID && RREADY) bptr++;
        if (forced_stall) stall_left--;
        case (phase)
            PH_IDLE: begin
                if (req_valid) begin
                    m_addr    = req_addr;
                    m_len     = req_len;
                    build_list();
                    m_cnt     = 0;
                    m_err     = 0;
                    bptr      = 0;
                    acc_cyc   = cyc;
                    force_req = 0;
                    phase     = PH_ADDR;
                end
            end
            PH_ADDR: begin
                if (ARREADY) begin
                    idle  = 0;
                    phase = PH_DATA;
                end
            end
            PH_DATA: begin
                if (exp_we) begin
                    if (bresp[m_cnt][1]) m_err = 1;
                    m_cnt++;
                    idle = 0;
                    last_beat_cyc = cyc;
                    if (m_cnt == bdata.size()) begin
                        if (m_mismatch) m_err = 1;
                        phase = PH_DONE;
                    end
                end else begin
`ifdef AXI_MRD_TIMEOUT_EN
                    idle++;
                    if (idle == TMO) begin
                        m_err = 1;
                        phase = PH_DONE;
                    end
`endif
                end
            end
            default: begin
                phase = PH_IDLE;
                txn_done++;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        #3;
        compare();
        update();
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_arvalid", 64'(ARVALID), 64'd0);
        chk("rst_rready", 64'(RREADY), 64'd0);
        chk("rst_fill_we", 64'(fill_we), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_araddr", 64'(ARADDR), 64'd0);
        chk("rst_arlen", 64'(ARLEN), 64'd0);
        chk("rst_fill_idx", 64'(fill_idx), 64'd0);
        chk("rst_fill_data", 64'(fill_data), 64'd0);
    endtask

    // Asserts reset a little after a clock edge, with whatever the slave presents this cycle.
    task automatic reset_dut();
        @(posedge clk);
        #1;
        drive();
        rst = 1'b1;
        #1;
        check_reset_vals();
        phase = PH_IDLE;
        m_addr = '0;
        m_len = '0;
        bdata.delete();
        bresp.delete();
        blast.delete();
        m_cnt = 0;
        bptr = 0;
        force_req = 0;
        stall_left = 0;
        req_valid = 1'b0;
        RVALID = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_hold_done", 64'(done), 64'd0);
            chk("rst_hold_req_ready", 64'(req_ready), 64'd0);
        end
        rst = 1'b0;
    endtask

    task automatic run_txn(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input int mode, input int k, input int max_cycles);
        int start, n;
        force_req = 1;
        f_addr = addr;
        f_len = len;
        f_mode = mode;
        f_k = k;
        start = txn_done;
        n = 0;
        while (txn_done == start && n < max_cycles) begin
            step();
            n++;
        end
        if (txn_done == start) fail_now("txn_bound");
        f_mode = -1;
        patch_idx = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, d0, n;
        rst = 1'b0;
        req_valid = 0; req_addr = '0; req_len = '0; ARREADY = 0;
        RVALID = 0; RDATA = '0; RLAST = 0; RRESP = '0; fill_stall = 0;
        #1;
        rst = 1'b1;
        #2;
        check_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Full burst, EXOKAY on last beat: 8 writes, done 10 cycles after accept, no error.
        patch_idx = 7;
        patch_val = 2'b01;
        wr0 = wr_cnt;
        run_txn(32'h100, 8'd7, 0, 0, 100);
        chk("t1_writes", 64'(wr_cnt - wr0), 64'd8);
        chk("t1_latency", 64'(done_cyc - acc_cyc), 64'd10);
        chk("t1_err", 64'(last_err), 64'd0);
        chk("t1_araddr", 64'(ARADDR), 64'h100);
        chk("t1_arlen", 64'(ARLEN), 64'd7);

        // Sink stalls three cycles after beat 1.
        stall_at = 2;
        stall_left = 3;
        wr0 = wr_cnt;
        run_txn($urandom, 8'd3, 0, 0, 100);
        chk("t2_writes", 64'(wr_cnt - wr0), 64'd4);
        chk("t2_latency", 64'(done_cyc - acc_cyc), 64'd9);
        chk("t2_err", 64'(last_err), 64'd0);

        // SLVERR on beat 2: all beats still written, error reported.
        patch_idx = 2;
        patch_val = 2'b10;
        wr0 = wr_cnt;
        run_txn($urandom, 8'd3, 0, 0, 100);
        chk("t3_writes", 64'(wr_cnt - wr0), 64'd4);
        chk("t3_err", 64'(last_err), 64'd1);

        // Early RLAST on beat 1 of len 3.
        wr0 = wr_cnt;
        run_txn($urandom, 8'd3, 1, 1, 100);
        chk("t4_writes", 64'(wr_cnt - wr0), 64'd2);
        chk("t4_err", 64'(last_err), 64'd1);

        // len 1 without RLAST.
        wr0 = wr_cnt;
        run_txn($urandom, 8'd1, 2, 0, 100);
        chk("t5_writes", 64'(wr_cnt - wr0), 64'd2);
        chk("t5_err", 64'(last_err), 64'd1);

        // Single beat: done 3 cycles after accept, back-to-back request spacing of 4.
        run_txn($urandom, 8'd0, 0, 0, 100);
        chk("t6_latency", 64'(done_cyc - acc_cyc), 64'd3);
        d0 = acc_cyc;
        run_txn($urandom, 8'd0, 0, 0, 100);
        chk("t6_spacing", 64'(acc_cyc - d0), 64'd4);

        // Maximum length: 256 beats, counter must not wrap before the end check.
        wr0 = wr_cnt;
        run_txn($urandom, 8'd255, 0, 0, 400);
        chk("t7_writes", 64'(wr_cnt - wr0), 64'd256);
        chk("t7_latency", 64'(done_cyc - acc_cyc), 64'd258);
        chk("t7_err", 64'(last_err), 64'd0);

        // Reset while beat 4 of len 7 is on the bus, then a clean request.
        d0 = done_seen;
        force_req = 1;
        f_addr = 32'h2000;
        f_len = 8'd7;
        f_mode = 0;
        n = 0;
        while (!(phase == PH_DATA && m_cnt == 4) && n < 50) begin
            step();
            n++;
        end
        if (n == 50) fail_now("t8_reach_beat4");
        f_mode = -1;
        reset_dut();
        chk("t8_no_done", 64'(done_seen - d0), 64'd0);
        wr0 = wr_cnt;
        run_txn(32'h3000, 8'd2, 0, 0, 100);
        chk("t8_writes", 64'(wr_cnt - wr0), 64'd3);
        chk("t8_err", 64'(last_err), 64'd0);

        // Slave goes silent after beat 2.
        stop_after = 3;
        d0 = done_seen;
        force_req = 1;
        f_addr = $urandom;
        f_len = 8'd7;
        f_mode = 0;
        repeat (40) step();
        f_mode = -1;
        stop_after = 100000;
`ifdef AXI_MRD_TIMEOUT_EN
        chk("t9_done", 64'(done_seen - d0), 64'd1);
        chk("t9_gap", 64'(done_cyc - last_beat_cyc), 64'(TMO + 1));
        chk("t9_err", 64'(last_err), 64'd1);
`else
        chk("t9_no_done", 64'(done_seen - d0), 64'd0);
`endif
        reset_dut();

        // Randomized traffic.
        p_req = 30;
        p_ar = 60;
        p_rv = 70;
        p_stall = 20;
        rand_resp = 1;
        d0 = txn_done;
        repeat (3000) step();
        p_req = 0;
        n = 0;
        while (phase != PH_IDLE && n < 2000) begin
            step();
            n++;
        end
        if (phase != PH_IDLE) fail_now("drain");
        chk("random_progress", 64'(txn_done - d0 > 50), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
